sram_like_arbiter: RTL

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/cpu_bus_pkg.sv | 18 +
 rtl/sram_like_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the SRAM-like CPU bus: arbiter FSM states, master
// owner IDs and transfer size codes.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter.sv
// Two-master (instruction/data) arbiter onto one SRAM-like slave bus, with at
// most one transaction outstanding and a latched request held stable in ADDR.
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok
);

  state_t      state, next_state;
  logic        owner, last_owner;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;
  logic        grant_valid, grant_owner;
  logic        addr_hs, data_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // On a tie, round-robin mode hands the bus to whoever did not own it last.
  always_comb begin
    grant_valid = inst_req | data_req;
    grant_owner = OWNER_INST;
    if (inst_req && data_req)
      grant_owner = DATA_PRIO ? OWNER_DATA : ~last_owner;
    else if (data_req)
      grant_owner = OWNER_DATA;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (grant_valid) next_state = ST_ADDR;
      ST_ADDR: if (bus_addr_ok) next_state = bus_data_ok ? ST_IDLE : ST_DATA;
      ST_DATA: if (bus_data_ok) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWNER_INST;
      last_owner <= OWNER_INST;
      lat_wr     <= 1'b0;
      lat_size   <= 2'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else if (state == ST_IDLE && grant_valid) begin
      owner      <= grant_owner;
      last_owner <= grant_owner;
      if (grant_owner == OWNER_DATA) begin
        lat_wr    <= data_wr;
        lat_size  <= data_size;
        lat_addr  <= data_addr;
        lat_wdata <= data_wdata;
      end else begin
        lat_wr    <= inst_wr;
        lat_size  <= inst_size;
        lat_addr  <= inst_addr;
        lat_wdata <= inst_wdata;
      end
    end
  end

  // Slave handshakes only reach the owner, and only in the states expecting them.
  always_comb begin
    addr_hs      = (state == ST_ADDR) && bus_addr_ok;
    data_hs      = ((state == ST_ADDR) && bus_addr_ok && bus_data_ok) ||
                   ((state == ST_DATA) && bus_data_ok);
    bus_req      = (state == ST_ADDR);
    bus_wr       = lat_wr;
    bus_size     = lat_size;
    bus_addr     = lat_addr;
    bus_wdata    = lat_wdata;
    inst_addr_ok = addr_hs && (owner == OWNER_INST);
    inst_data_ok = data_hs && (owner == OWNER_INST);
    data_addr_ok = addr_hs && (owner == OWNER_DATA);
    data_data_ok = data_hs && (owner == OWNER_DATA);
    inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    data_rdata   = data_data_ok ? bus_rdata : 32'd0;
  end

endmodule
